// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: WIDTH-cycle shift-add multiply and restoring divide
// on operand magnitudes, with sign correction folded into the final iteration.
//
//   state | meaning
//   IDLE  | waiting for start_i
//   CALC  | one multiply/divide iteration per cycle, busy_o high
//   DONE  | result valid, done_o pulse; start_i accepted back-to-back
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic             is_div, neg_a, neg_b, div_zero;
    logic [WIDTH-1:0] mag_a, mag_b, acc_hi, acc_lo;

    logic             accept, last_iter;
    logic             src1_neg, src2_neg;
    logic [WIDTH-1:0] src1_mag, src2_mag;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               fits;
    logic [WIDTH-1:0]   hi_nx, lo_nx;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

    assign accept    = start_i && (state == IDLE || state == DONE);
    assign last_iter = (state == CALC) && (cnt == CW'(WIDTH - 1));

    assign src1_neg = op_i[0] & src1_i[WIDTH-1];
    assign src2_neg = op_i[0] & src2_i[WIDTH-1];
    assign src1_mag = src1_neg ? -src1_i : src1_i;
    assign src2_mag = src2_neg ? -src2_i : src2_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = CALC;
            CALC:    if (last_iter) state_nx = DONE;
            DONE:    state_nx = start_i ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One datapath step; the product/quotient shifts through acc_lo
    always_comb begin
        addend  = acc_lo[0] ? mag_a : '0;
        sum     = {1'b0, acc_hi} + {1'b0, addend};
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        fits    = rem_sh >= {1'b0, mag_b};
        // true difference is below 2^WIDTH, so the modulo subtraction is exact
        rem_sub = rem_sh[WIDTH-1:0] - mag_b;
        if (is_div) begin
            hi_nx = fits ? rem_sub : rem_sh[WIDTH-1:0];
            lo_nx = {acc_lo[WIDTH-2:0], fits};
        end else begin
            hi_nx = sum[WIDTH:1];
            lo_nx = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // A zero divisor leaves the magnitude dividend as remainder, so hi already equals src1
    always_comb begin
        prod     = {hi_nx, lo_nx};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix  = (neg_a ^ neg_b) ? -lo_nx : lo_nx;
        rem_fix  = neg_a ? -hi_nx : hi_nx;
        res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = is_div ? (div_zero ? '1 : quo_fix) : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else begin
            busy_o <= (state_nx == CALC);
            done_o <= (state_nx == DONE);
            if (accept) begin
                is_div   <= op_i[1];
                neg_a    <= src1_neg;
                neg_b    <= src2_neg;
                div_zero <= (src2_i == '0);
                mag_a    <= src1_mag;
                mag_b    <= src2_mag;
                acc_hi   <= '0;
                acc_lo   <= op_i[1] ? src1_mag : src2_mag;
                cnt      <= '0;
            end else if (state == CALC) begin
                acc_hi <= hi_nx;
                acc_lo <= lo_nx;
                cnt    <= cnt + 1'b1;
                if (last_iter) begin
                    hi_o <= res_hi;
                    lo_o <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner vectors, randomized operations
// against an arithmetic reference model, back-to-back issue and reset abort.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i = 2'd0;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic         busy_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    int vectors = 0;
    int miscompares = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    // Reference result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        case (op)
            2'd0: return {32'b0, a} * {32'b0, b};
            2'd1: return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
        endcase
    endfunction

    // Issue one op from IDLE and wait for done_o; garbage on inputs after acceptance
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, output logic [31:0] hi, output logic [31:0] lo,
                          output int lat, output bit held, output bit busy_ok);
        logic [31:0] hi0, lo0;
        @(negedge clk_i);
        op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        hi0 = hi_o; lo0 = lo_o;
        held = 1'b1; busy_ok = 1'b1; lat = 0;
        while (!done_o && lat < 100) begin
            op_i = 2'($urandom); src1_i = $urandom; src2_i = $urandom;
            start_i = (noise && lat < 28) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!busy_o) busy_ok = 1'b0;
            if (hi_o !== hi0 || lo_o !== lo0) held = 1'b0;
            @(posedge clk_i); #1;
            lat++;
        end
        start_i = 1'b0;
        hi = hi_o; lo = lo_o;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        vectors++;
        if ({busy_o, done_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags: busy/done got %b, want 00", {busy_o, done_o});
        end
        vectors++;
        if (hi_o !== '0 || lo_o !== '0) begin
            miscompares++;
            $display("FAIL reset_result: hi/lo got %h/%h, want 0/0", hi_o, lo_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3};
        logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_1234, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ehi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0};
        logic [31:0] elo [5] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] hi, lo;
        int lat;
        bit held, busy_ok;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, hi, lo, lat, held, busy_ok);
            vectors++;
            if (lat !== 32) begin
                miscompares++;
                $display("FAIL dir%0d_latency: got %0d cycles, want 32", i, lat);
            end
            vectors++;
            if (hi !== ehi[i] || lo !== elo[i]) begin
                miscompares++;
                $display("FAIL dir%0d_result: hi/lo got %h/%h, want %h/%h", i, hi, lo, ehi[i], elo[i]);
            end
            vectors++;
            if (!busy_ok || !held || busy_o !== 1'b0) begin
                miscompares++;
                $display("FAIL dir%0d_calc: busy_ok=%0d held=%0d busy_at_done=%b, want 1 1 0", i, busy_ok, held, busy_o);
            end
            @(posedge clk_i); #1;
            vectors++;
            if (done_o !== 1'b0) begin
                miscompares++;
                $display("FAIL dir%0d_pulse: done_o got %b one cycle later, want 0", i, done_o);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        logic [1:0]  op;
        int lat;
        bit held, busy_ok;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if (op[1] && $urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 31);
            exp = ref_model(op, a, b);
            run_op(op, a, b, 1'b1, hi, lo, lat, held, busy_ok);
            vectors++;
            if (hi !== exp[63:32] || lo !== exp[31:0] || lat !== 32 || !held || !busy_ok) begin
                miscompares++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got %h/%h lat=%0d held=%0d busy=%0d, want %h/%h lat=32",
                         i, op, a, b, hi, lo, lat, held, busy_ok, exp[63:32], exp[31:0]);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  ops [4];
        logic [31:0] as [4], bs [4];
        logic [63:0] exp;
        int edges, idx, guard;
        for (int i = 0; i < 4; i++) begin
            ops[i] = 2'($urandom); as[i] = $urandom; bs[i] = $urandom;
        end
        @(negedge clk_i);
        op_i = ops[0]; src1_i = as[0]; src2_i = bs[0]; start_i = 1'b1;
        @(posedge clk_i); #1;
        edges = 0; idx = 0; guard = 0;
        while (idx < 4 && guard < 400) begin
            @(posedge clk_i); #1;
            edges++; guard++;
            if (done_o) begin
                exp = ref_model(ops[idx], as[idx], bs[idx]);
                vectors++;
                if (hi_o !== exp[63:32] || lo_o !== exp[31:0] || edges !== (idx == 0 ? 32 : 33)) begin
                    miscompares++;
                    $display("FAIL b2b%0d: got %h/%h after %0d cycles, want %h/%h after %0d",
                             idx, hi_o, lo_o, edges, exp[63:32], exp[31:0], (idx == 0 ? 32 : 33));
                end
                idx++;
                edges = 0;
                if (idx < 4) begin
                    op_i = ops[idx]; src1_i = as[idx]; src2_i = bs[idx];
                end else begin
                    start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        vectors++;
        if (idx !== 4) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d results, want 4", idx);
        end
        @(posedge clk_i); #1;
        vectors++;
        if ({busy_o, done_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_idle: busy/done got %b, want 00", {busy_o, done_o});
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] hi, lo;
        logic [63:0] exp;
        int lat, dones;
        bit held, busy_ok;
        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, hi, lo, lat, held, busy_ok);
        @(posedge clk_i); #1;
        vectors++;
        if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL abort_setup: hi/lo got %h/%h, want 00000001/fffffffe", hi_o, lo_o);
        end
        @(negedge clk_i);
        op_i = 2'd1; src1_i = 32'h1234_5678; src2_i = 32'h9ABC_DEF0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        vectors++;
        if (busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy_before: busy_o got %b, want 1", busy_o);
        end
        rst_i = 1'b0;
        #1;
        vectors++;
        if ({busy_o, done_o} !== 2'b00 || hi_o !== '0 || lo_o !== '0) begin
            miscompares++;
            $display("FAIL abort_immediate: busy/done=%b hi/lo=%h/%h, want 00 0/0", {busy_o, done_o}, hi_o, lo_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        dones = 0;
        repeat (50) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d cycles with busy/done, want 0", dones);
        end
        exp = ref_model(2'd3, 32'hFFFF_FF9C, 32'd7);
        run_op(2'd3, 32'hFFFF_FF9C, 32'd7, 1'b0, hi, lo, lat, held, busy_ok);
        vectors++;
        if (hi !== exp[63:32] || lo !== exp[31:0] || lat !== 32) begin
            miscompares++;
            $display("FAIL abort_restart: got %h/%h lat=%0d, want %h/%h lat=32", hi, lo, lat, exp[63:32], exp[31:0]);
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
